// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM states, watchdog limits.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    localparam int MEM_TIMEOUT = 16;
    localparam int MEM_CNT_W   = 5;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Saturating stall counter for a granted RAM access; expired flags the TIMEOUT-th stalled cycle.
// Latency: expired is combinational on en, so the FSM can leave on that same cycle's edge.
module mem_watchdog
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CNT_W   = MEM_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt < LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt counts previous stalled cycles, so the current one is the TIMEOUT-th when cnt hits LAST
    assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates datapath fetch vs load/store onto one single-ported RAM; data access wins over fetch.
// Latency: 1 idle grant cycle then RAM-paced; requesters are held with iwait/dwait until ACCESS.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CNT_W   = MEM_CNT_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    arb_state_t state, next_state;
    ramstate_t  rs;
    word_t      addr_q, store_q;
    logic       op_store_q;
    logic       cap_d, cap_i, wd_en, owner_req, expired;

    assign rs = ramstate_t'(ramstate);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .en      (wd_en),
        .clr     (!wd_en),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            op_store_q <= 1'b0;
        end else begin
            state <= next_state;
            if (cap_d) begin
                addr_q     <= daddr;
                store_q    <= dstore;
                op_store_q <= dWEN;
            end else if (cap_i) begin
                addr_q     <= iaddr;
                op_store_q <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        cap_d      = 1'b0;
        cap_i      = 1'b0;
        wd_en      = 1'b0;
        owner_req  = 1'b0;
        case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    next_state = DACC;
                    cap_d      = 1'b1;
                end else if (iREN) begin
                    next_state = IACC;
                    cap_i      = 1'b1;
                end
            end
            DACC, IACC: begin
                wd_en     = (rs != ACCESS);
                owner_req = (state == DACC) ? (dREN || dWEN) : iREN;
                // RAM error outranks completion; a dropped request is a flush and returns quietly
                if (rs == ERROR) begin
                    next_state = ERR;
                end else if (rs == ACCESS) begin
                    next_state = IDLE;
                end else if (!owner_req) begin
                    next_state = IDLE;
                end else if (expired) begin
                    next_state = ERR;
                end
            end
            default: next_state = ERR;
        endcase
    end

    assign ramREN   = (state == IACC) || ((state == DACC) && !op_store_q);
    assign ramWEN   = (state == DACC) && op_store_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iload    = ramload;
    assign dload    = ramload;
    assign iwait    = !((state == IACC) && (rs == ACCESS));
    assign dwait    = !((state == DACC) && (rs == ACCESS));
    assign mem_err  = (state == ERR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus queues expected completions, a monitor pops on wait=0.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .iload    (iload),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  is_load;
        word_t addr;
        word_t data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic push_i(input word_t a, input word_t d);
        exp_t e;
        e.is_load = 1'b1;
        e.addr    = a;
        e.data    = d;
        iq.push_back(e);
    endtask

    task automatic push_d(input logic ld, input word_t a, input word_t d);
        exp_t e;
        e.is_load = ld;
        e.addr    = a;
        e.data    = d;
        dq.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    // Monitor: any wait=0 must match the oldest queued request of that port
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (!iwait) begin
                if (iq.size() == 0) begin
                    total++;
                    $display("FAIL fetch_spurious: iwait=0 at ramaddr=%h, none pending", ramaddr);
                end else begin
                    e = iq.pop_front();
                    check("fetch_ramaddr", ramaddr, e.addr);
                    check("fetch_iload", iload, e.data);
                end
            end
            if (!dwait) begin
                if (dq.size() == 0) begin
                    total++;
                    $display("FAIL data_spurious: dwait=0 at ramaddr=%h, none pending", ramaddr);
                end else begin
                    e = dq.pop_front();
                    check("data_ramaddr", ramaddr, e.addr);
                    if (e.is_load) check("data_dload", dload, e.data);
                    else           check("data_ramstore", ramstore, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #2;
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        #5;
        iREN = 1'b0; dWEN = 1'b0; RST = 1'b0;
        tick();

        // 1: fetch alone, ACCESS on third cycle of the request
        iREN = 1'b1; iaddr = 32'h40; push_i(32'h40, 32'h3C010001);
        mid(); check("t1_idle_no_strobe", 32'(ramREN), 32'd0);
        tick(); ramstate = BUSY;
        mid();
        check("t1_ramREN_c2", 32'(ramREN), 32'd1);
        check("t1_ramaddr", ramaddr, 32'h40);
        check("t1_iwait_busy", 32'(iwait), 32'd1);
        tick(); ramstate = ACCESS; ramload = 32'h3C010001;
        mid(); check("t1_ramREN_c3", 32'(ramREN), 32'd1);
        tick(); iREN = 1'b0; ramstate = FREE; ramload = '0;
        mid();
        check("t1_ramREN_after", 32'(ramREN), 32'd0);
        check("t1_iwait_after", 32'(iwait), 32'd1);

        // 2: simultaneous fetch and load, data first
        tick(); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h100;
        push_d(1'b1, 32'h100, 32'h11111111); push_i(32'h44, 32'h22222222);
        mid(); check("t2_dwait_grant", 32'(dwait), 32'd1);
        tick(); ramstate = ACCESS; ramload = 32'h11111111;
        mid(); check("t2_fetch_held", 32'(iwait), 32'd1);
        tick(); dREN = 1'b0; ramstate = FREE;
        mid(); check("t2_idle_gap", 32'(ramREN), 32'd0);
        tick(); ramstate = ACCESS; ramload = 32'h22222222;
        mid(); check("t2_fetch_ramREN", 32'(ramREN), 32'd1);
        tick(); iREN = 1'b0; ramstate = FREE;

        // 3: store, address/data change while granted must be ignored
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        push_d(1'b0, 32'h200, 32'hDEADBEEF);
        mid();
        tick(); ramstate = BUSY;
        mid();
        check("t3_ramWEN", 32'(ramWEN), 32'd1);
        check("t3_ramREN", 32'(ramREN), 32'd0);
        check("t3_ramaddr", ramaddr, 32'h200);
        check("t3_ramstore", ramstore, 32'hDEADBEEF);
        check("t3_dwait_busy", 32'(dwait), 32'd1);
        tick(); ramstate = ACCESS; daddr = 32'h204; dstore = '0;
        mid();
        check("t3_ramWEN_acc", 32'(ramWEN), 32'd1);
        check("t3_ramREN_acc", 32'(ramREN), 32'd0);
        tick(); dWEN = 1'b0; ramstate = FREE;
        mid(); check("t3_ramWEN_after", 32'(ramWEN), 32'd0);

        // 4: fetch flushed while RAM busy
        tick(); iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
        mid();
        tick(); mid(); check("t4_ramREN_granted", 32'(ramREN), 32'd1);
        tick(); iREN = 1'b0;
        mid();
        tick(); ramstate = ACCESS;
        mid();
        check("t4_ramREN_flushed", 32'(ramREN), 32'd0);
        check("t4_iwait_no_pulse", 32'(iwait), 32'd1);
        tick(); ramstate = FREE;

        // 5: watchdog timeout after 16 stalled granted cycles
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        mid();
        for (int i = 0; i < 16; i++) begin
            tick();
            mid();
        end
        check("t5_no_err_at_16", 32'(mem_err), 32'd0);
        check("t5_ramREN_at_16", 32'(ramREN), 32'd1);
        tick(); mid();
        check("t5_mem_err", 32'(mem_err), 32'd1);
        check("t5_ramREN_err", 32'(ramREN), 32'd0);
        check("t5_ramWEN_err", 32'(ramWEN), 32'd0);
        check("t5_dwait_err", 32'(dwait), 32'd1);
        tick(); dREN = 1'b0; iREN = 1'b1; ramstate = ACCESS;
        mid();
        check("t5_err_sticky", 32'(mem_err), 32'd1);
        check("t5_iwait_err", 32'(iwait), 32'd1);
        check("t5_ramREN_sticky", 32'(ramREN), 32'd0);
        tick(); iREN = 1'b0; RST = 1'b1;
        #1 check("t5_err_cleared", 32'(mem_err), 32'd0);
        #1 RST = 1'b0; ramstate = FREE;

        // 6: asynchronous reset in the middle of a data access
        tick(); dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        mid();
        tick(); mid(); check("t6_ramREN_granted", 32'(ramREN), 32'd1);
        tick();
        #1 RST = 1'b1;
        #1;
        check("t6_ramREN_async", 32'(ramREN), 32'd0);
        check("t6_mem_err", 32'(mem_err), 32'd0);
        check("t6_ramaddr_cleared", ramaddr, 32'h0);
        #1 RST = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick(); mid(); check("t6_idle_after", 32'(ramREN), 32'd0);

        // post-reset fetch granted straight from IDLE
        tick(); iREN = 1'b1; iaddr = 32'h48; push_i(32'h48, 32'h00000055);
        mid();
        tick(); ramstate = ACCESS; ramload = 32'h00000055;
        mid();
        tick(); iREN = 1'b0; ramstate = FREE;
        mid();

        check("iq_drained", 32'(iq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
